// File: rtl/quantize.sv
// quantize: two-stage shift/round/saturate stage that narrows a signed
// accumulator result (ARGW bits) to a signed output word (RESW bits).
// S1 holds the arithmetically shifted value, S2 holds the clipped result.
// Build option: define QUANTIZE_ROUND_EN to round half up before shifting;
// without it S1 truncates toward minus infinity.
module quantize #(
    parameter int ARGW  = 40,
    parameter int RESW  = 16,
    parameter int SHIFT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arg_valid,
    input  logic [ARGW-1:0] arg_data,
    output logic            arg_ready,
    output logic            res_valid,
    output logic [RESW-1:0] res_data,
    input  logic            res_ready,
    output logic            res_sat,
    output logic            overflow
);

    // The guard bits are S1 bits [ARGW:RESW-1]; they must all equal the
    // sign bit for the value to fit in RESW bits.
    localparam int GUARDW = ARGW - RESW + 2;

    localparam logic [RESW-1:0] RES_MAX = {1'b0, {(RESW-1){1'b1}}};
    localparam logic [RESW-1:0] RES_MIN = {1'b1, {(RESW-1){1'b0}}};

`ifdef QUANTIZE_ROUND_EN
    localparam int ROUND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ARGW:0] ROUND_ADD =
        (SHIFT > 0) ? ((ARGW+1)'(1) << ROUND_POS) : '0;
`else
    localparam logic [ARGW:0] ROUND_ADD = '0;
`endif

    // Pipeline state
    logic            s1Valid_q, s1Valid_d;
    logic [ARGW:0]   s1Data_q,  s1Data_d;
    logic            s2Valid_q, s2Valid_d;
    logic [RESW-1:0] s2Data_q,  s2Data_d;
    logic            s2Sat_q,   s2Sat_d;
    logic            overflow_q, overflow_d;

    // Handshake and datapath intermediates
    logic                 s2Adv;
    logic                 s1Adv;
    logic [ARGW:0]        argExt;
    logic [ARGW:0]        roundSum;
    logic signed [ARGW:0] shiftVal;
    logic [GUARDW-1:0]    guardBits;
    logic                 inRange;
    logic [RESW-1:0]      clipData;

    // S2 moves whenever its slot is free or being drained; S1 moves when
    // S2 takes its contents or when S1 has nothing to hand over.
    always_comb begin
        s2Adv     = !s2Valid_q || res_ready;
        s1Adv     = s2Adv || !s1Valid_q;
        arg_ready = s1Adv;
    end

    // Sign-extend by one bit first so the rounding add can never wrap,
    // then shift arithmetically to drop the fractional bits.
    always_comb begin
        argExt   = {arg_data[ARGW-1], arg_data};
        roundSum = argExt + ROUND_ADD;
        shiftVal = $signed(roundSum) >>> SHIFT;
    end

    // Clip the S1 value to the RESW range; out of range when the guard
    // bits are not a pure sign extension.
    always_comb begin
        guardBits = s1Data_q[ARGW:RESW-1];
        inRange   = (&guardBits) || !(|guardBits);
        if (inRange) begin
            clipData = s1Data_q[RESW-1:0];
        end else if (s1Data_q[ARGW]) begin
            clipData = RES_MIN;
        end else begin
            clipData = RES_MAX;
        end
    end

    // Next-state for both stages and the sticky overflow flag.
    always_comb begin
        s1Valid_d  = s1Valid_q;
        s1Data_d   = s1Data_q;
        s2Valid_d  = s2Valid_q;
        s2Data_d   = s2Data_q;
        s2Sat_d    = s2Sat_q;
        overflow_d = overflow_q;

        if (s1Adv) begin
            s1Valid_d = arg_valid;
            if (arg_valid) begin
                s1Data_d = shiftVal;
            end
        end

        if (s2Adv) begin
            s2Valid_d = s1Valid_q;
            s2Sat_d   = s1Valid_q && !inRange;
            if (s1Valid_q) begin
                s2Data_d = clipData;
            end
            if (s1Valid_q && !inRange) begin
                overflow_d = 1'b1;
            end
        end
    end

    // State registers; reset empties the pipeline and clears the flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1Data_q   <= '0;
            s2Valid_q  <= 1'b0;
            s2Data_q   <= '0;
            s2Sat_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Data_q   <= s1Data_d;
            s2Valid_q  <= s2Valid_d;
            s2Data_q   <= s2Data_d;
            s2Sat_q    <= s2Sat_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs come straight from S2 registers.
    always_comb begin
        res_valid = s2Valid_q;
        res_data  = s2Data_q;
        res_sat   = s2Sat_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_quantize.sv
// tb_quantize: randomized and directed stimulus for quantize, checked
// against an arithmetic reference model and a queue of expected results.
// Build with QUANTIZE_ROUND_EN defined to exercise the rounding variant.
module tb_quantize;

    localparam int ARGW  = 40;
    localparam int RESW  = 16;
    localparam int SHIFT = 8;

    typedef struct {
        logic [RESW-1:0] d;
        logic            s;
    } exp_t;

`ifdef QUANTIZE_ROUND_EN
    localparam logic [RESW-1:0] EXP_180 = 16'h0002;
    localparam logic [RESW-1:0] EXP_NEG = 16'h0000;
`else
    localparam logic [RESW-1:0] EXP_180 = 16'h0001;
    localparam logic [RESW-1:0] EXP_NEG = 16'hFFFF;
`endif

    logic            clk;
    logic            rst;
    logic            arg_valid;
    logic [ARGW-1:0] arg_data;
    logic            arg_ready;
    logic            res_valid;
    logic [RESW-1:0] res_data;
    logic            res_ready;
    logic            res_sat;
    logic            overflow;

    int   errors = 0;
    int   checks = 0;
    exp_t expQ[$];
    logic modelOv = 1'b0;
    exp_t monE;

    quantize #(.ARGW(ARGW), .RESW(RESW), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .arg_valid (arg_valid),
        .arg_data  (arg_data),
        .arg_ready (arg_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .res_sat   (res_sat),
        .overflow  (overflow)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sign-extend, optionally add half an LSB, floor-shift, clip.
    function automatic exp_t modelOf(input logic [ARGW-1:0] a);
        longint v;
        exp_t   r;
        v = $signed(a);
`ifdef QUANTIZE_ROUND_EN
        if (SHIFT > 0) v = v + (longint'(1) << (SHIFT - 1));
`endif
        v = v >>> SHIFT;
        if (v > 32767) begin
            r.d = 16'h7FFF;
            r.s = 1'b1;
        end else if (v < -32768) begin
            r.d = 16'h8000;
            r.s = 1'b1;
        end else begin
            r.d = v[RESW-1:0];
            r.s = 1'b0;
        end
        return r;
    endfunction

    // Mix of full-range, small, and near-saturation argument values.
    function automatic logic [ARGW-1:0] genArg();
        longint      v;
        logic [63:0] raw;
        raw = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       v = raw;
            1:       v = $signed(raw[23:0]);
            2:       v = (longint'(32767) <<< 8) + longint'($urandom_range(0, 511)) - 256;
            default: v = -(longint'(32768) <<< 8) + longint'($urandom_range(0, 511)) - 256;
        endcase
        return v[ARGW-1:0];
    endfunction

    // Compare process: every result the DUT presents must match the head of
    // the expected queue; accepted arguments feed the queue via the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResult", 64'd1, 64'd0);
                end else begin
                    monE = expQ[0];
                    if (monE.s) modelOv = 1'b1;
                    checkOutput("resData", 64'(res_data), 64'(monE.d));
                    checkOutput("resSat", 64'(res_sat), 64'(monE.s));
                    if (res_ready) void'(expQ.pop_front());
                end
            end
            checkOutput("overflow", 64'(overflow), 64'(modelOv));
            if (arg_valid && arg_ready) expQ.push_back(modelOf(arg_data));
        end
    end

    // Offer one argument (called at posedge+1) until accepted, bounded.
    task automatic applyStimulus(input logic [ARGW-1:0] a);
        bit ok;
        ok        = 1'b0;
        arg_data  = a;
        arg_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (arg_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        arg_valid = 1'b0;
        if (!ok) checkOutput("acceptTimeout", 64'd0, 64'd1);
    endtask

    // Send one value into an idle pipeline and check the literal result.
    task automatic sendAndExpect(input string name, input logic [ARGW-1:0] a,
                                 input logic [RESW-1:0] expD, input logic expS);
        bit              found;
        logic [RESW-1:0] gotD;
        logic            gotS;
        found = 1'b0;
        gotD  = '0;
        gotS  = 1'b0;
        applyStimulus(a);
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (res_valid) begin
                found = 1'b1;
                gotD  = res_data;
                gotS  = res_sat;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({name, "Found"}, 64'(found), 64'd1);
        checkOutput({name, "Data"}, 64'(gotD), 64'(expD));
        checkOutput({name, "Sat"}, 64'(gotS), 64'(expS));
    endtask

    logic [ARGW-1:0] bpVals [3];
    logic [3:0]      readyLog;
    logic [RESW-1:0] bpGot [3];
    logic [11:0]     streamVec;
    logic [11:0]     streamExp;
    logic [ARGW-1:0] bndVals [6];
    int              idx;
    int              gotCount;
    bit              acc;

    initial begin
        rst       = 1'b1;
        arg_valid = 1'b0;
        arg_data  = '0;
        res_ready = 1'b1;

        // Reset state while rst is held
        #1;
        checkOutput("rstResValid", 64'(res_valid), 64'd0);
        checkOutput("rstResData", 64'(res_data), 64'd0);
        checkOutput("rstResSat", 64'(res_sat), 64'd0);
        checkOutput("rstOverflow", 64'(overflow), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstArgReady", 64'(arg_ready), 64'd1);
        @(posedge clk);
        #1;

        // Pin the model to hand-computed values
        checkOutput("modelRound", 64'(modelOf(40'h0000000180).d), 64'(EXP_180));
        checkOutput("modelNeg", 64'(modelOf(40'hFFFFFFFF80).d), 64'(EXP_NEG));
        checkOutput("modelSatHi", 64'(modelOf(40'h0000800000).d), 64'h7FFF);
        checkOutput("modelSatLo", 64'(modelOf(40'hFF7FFFFF00).d), 64'h8000);

        // Rounding, negative, saturation literals
        sendAndExpect("round180", 40'h0000000180, EXP_180, 1'b0);
        sendAndExpect("negHalf", 40'hFFFFFFFF80, EXP_NEG, 1'b0);
        checkOutput("overflowClear", 64'(overflow), 64'd0);
        sendAndExpect("satHi", 40'h0000800000, 16'h7FFF, 1'b1);
        sendAndExpect("satLo", 40'hFF7FFFFF00, 16'h8000, 1'b1);
        sendAndExpect("afterSat", 40'h0000000100, 16'h0001, 1'b0);
        checkOutput("overflowSticky", 64'(overflow), 64'd1);

        // Range edges, checked against the model
        bndVals = '{40'h00007FFF00, 40'h00007FFFFF, 40'hFFFF800000,
                    40'hFFFF7FFFFF, 40'h0000000000, 40'h00000000FF};
        foreach (bndVals[i]) begin
            sendAndExpect("boundary", bndVals[i], modelOf(bndVals[i]).d,
                          modelOf(bndVals[i]).s);
        end

        // Backpressure: two accepted, then arg_ready drops, outputs hold
        bpVals    = '{40'h0000000100, 40'h0000000200, 40'h0000000300};
        res_ready = 1'b0;
        idx       = 0;
        arg_data  = bpVals[0];
        arg_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            readyLog[c] = arg_ready;
            if (c >= 2) begin
                checkOutput("bpHoldValid", 64'(res_valid), 64'd1);
                checkOutput("bpHoldData", 64'(res_data), 64'h0001);
            end
            if (arg_ready) idx++;
            @(posedge clk);
            #1;
            if (idx < 3) arg_data = bpVals[idx];
        end
        checkOutput("bpReadyPattern", 64'(readyLog), 64'b0011);
        checkOutput("bpAccepted", 64'(idx), 64'd2);
        res_ready = 1'b1;
        gotCount  = 0;
        for (int c = 0; c < 12 && gotCount < 3; c++) begin
            @(negedge clk);
            if (res_valid) begin
                bpGot[gotCount] = res_data;
                gotCount++;
            end
            if (arg_valid && arg_ready) idx++;
            @(posedge clk);
            #1;
            if (idx >= 3) arg_valid = 1'b0;
            else arg_data = bpVals[idx];
        end
        arg_valid = 1'b0;
        checkOutput("bpResultCount", 64'(gotCount), 64'd3);
        checkOutput("bpOrder0", 64'(bpGot[0]), 64'h0001);
        checkOutput("bpOrder1", 64'(bpGot[1]), 64'h0002);
        checkOutput("bpOrder2", 64'(bpGot[2]), 64'h0003);
        repeat (3) @(posedge clk);
        #1;

        // Streaming: 8 back-to-back values, results 2 cycles after first accept
        streamExp = '0;
        for (int i = 2; i < 10; i++) streamExp[i] = 1'b1;
        arg_data  = genArg();
        arg_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) checkOutput("streamArgReady", 64'(arg_ready), 64'd1);
            streamVec[c] = res_valid;
            @(posedge clk);
            #1;
            if (c + 1 < 8) arg_data = genArg();
            else arg_valid = 1'b0;
        end
        checkOutput("streamValidPattern", 64'(streamVec), 64'(streamExp));

        // Randomized valid/ready traffic
        arg_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = arg_valid && arg_ready;
            @(posedge clk);
            #1;
            if (acc || !arg_valid) begin
                arg_valid = ($urandom_range(0, 3) != 0);
                arg_data  = genArg();
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        arg_valid = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drainEmpty", 64'(expQ.size()), 64'd0);

        // Reset with both stages full, then a fresh value
        res_ready = 1'b0;
        applyStimulus(40'h0000800000);
        applyStimulus(40'h0000000100);
        @(negedge clk);
        checkOutput("fullResValid", 64'(res_valid), 64'd1);
        checkOutput("fullOverflow", 64'(overflow), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        expQ.delete();
        modelOv = 1'b0;
        #1;
        checkOutput("midRstResValid", 64'(res_valid), 64'd0);
        checkOutput("midRstOverflow", 64'(overflow), 64'd0);
        checkOutput("midRstResData", 64'(res_data), 64'd0);
        checkOutput("midRstResSat", 64'(res_sat), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midRstArgReady", 64'(arg_ready), 64'd1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        sendAndExpect("postRst", 40'h0000000100, 16'h0001, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("postRstQueue", 64'(expQ.size()), 64'd0);
        checkOutput("postRstOverflow", 64'(overflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
